// File: rtl/clk_en_sched.sv
// Single-clock enable scheduler: divided strobe grants one round-robin requester a counter sample.
// strobe/grant/sample/overrun land one cycle after the strobe condition; a full, unaccepted slot turns the strobe into an overrun pulse.
module clk_en_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 8,
    parameter int DW   = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset_l,
    input  logic            run,
    input  logic [DW-1:0]   div,
    input  logic            load_div,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            strobe,
    output logic [CW-1:0]   cnt,
    output logic [CW-1:0]   sample,
    output logic [IW-1:0]   sample_id,
    output logic            sample_valid,
    input  logic            sample_ready,
    output logic            overrun
);

    logic [DW-1:0]   ratio;
    logic [DW-1:0]   div_cnt;
    logic [DW-1:0]   ratio_last;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   rr_nxt;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   sel_idx;
    logic            pick_vld;
    logic            strobe_cond;
    logic            slot_free;
    logic            do_grant;
    logic            do_overrun;
    logic [NREQ-1:0] grant_nxt;

    assign ratio_last  = ratio - DW'(1);
    assign strobe_cond = run && (div_cnt == ratio_last);
    assign slot_free   = !sample_valid || sample_ready;
    assign do_grant    = strobe_cond && pick_vld && slot_free;
    assign do_overrun  = strobe_cond && pick_vld && !slot_free;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        sel_idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sel_idx = IW'((int'(rr_ptr) + i) % NREQ);
            if (req[sel_idx]) begin
                pick_vld = 1'b1;
                pick_idx = sel_idx;
            end
        end
    end

    assign rr_nxt    = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
    assign grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            ratio   <= DW'(1);
            div_cnt <= '0;
            cnt     <= '0;
            strobe  <= 1'b0;
        end else begin
            strobe <= strobe_cond;
            if (run) begin
                cnt <= cnt + CW'(1);
            end
            if (load_div) begin
                ratio <= (div == '0) ? DW'(1) : div;
            end
            if (!run || load_div || strobe_cond) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // sample takes cnt as registered this cycle, i.e. before this edge's increment.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rr_ptr       <= '0;
            grant        <= '0;
            sample       <= '0;
            sample_id    <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            grant   <= do_grant ? grant_nxt : '0;
            overrun <= do_overrun;
            if (do_grant) begin
                sample       <= cnt;
                sample_id    <= pick_idx;
                sample_valid <= 1'b1;
                rr_ptr       <= rr_nxt;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_en_sched.sv
// Bench for clk_en_sched: directed scenarios push expected grants to a queue; a negedge monitor pops and compares.
module tb_clk_en_sched;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic       run = 1'b0;
    logic [3:0] div = 4'd0;
    logic       load_div = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] grant;
    logic       strobe;
    logic [7:0] cnt;
    logic [7:0] sample;
    logic [1:0] sample_id;
    logic       sample_valid;
    logic       sample_ready = 1'b0;
    logic       overrun;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic [7:0] s;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [1:0] exp_ptr = 2'd0;

    clk_en_sched #(.NREQ(4), .CW(8), .DW(4)) dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .run          (run),
        .div          (div),
        .load_div     (load_div),
        .req          (req),
        .grant        (grant),
        .strobe       (strobe),
        .cnt          (cnt),
        .sample       (sample),
        .sample_id    (sample_id),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] id, input logic [7:0] s);
        exp_t e;
        e.g  = g;
        e.id = id;
        e.s  = s;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset_l === 1'b1 && grant !== 4'b0000) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got grant=%b id=%0d sample=%0d, expected no grant", grant, sample_id, sample);
            end else begin
                mon_e = q.pop_front();
                if (grant !== mon_e.g || sample_id !== mon_e.id || sample !== mon_e.s || sample_valid !== 1'b1 || strobe !== 1'b1) begin
                    errors++;
                    $display("FAIL grant_sample: got grant=%b id=%0d sample=%0d valid=%b strobe=%b, expected grant=%b id=%0d sample=%0d valid=1 strobe=1",
                             grant, sample_id, sample, sample_valid, strobe, mon_e.g, mon_e.id, mon_e.s);
                end
            end
        end
    end

    task automatic tick();
        if (run && reset_l) exp_cnt = exp_cnt + 8'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_l = 1'b0; run = 1'b0; div = 4'd0; load_div = 1'b0; req = 4'd0; sample_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        checks++;
        if (grant !== 4'd0 || sample_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got grant=%b id=%0d expected 0 0", grant, sample_id); end
        checks++;
        if (sample !== 8'd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", sample); end
        checks++;
        if ({strobe, sample_valid, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got strobe/valid/overrun=%b expected 000", {strobe, sample_valid, overrun}); end
        reset_l = 1'b1;
        exp_cnt = 8'd0;
        exp_ptr = 2'd0;
    endtask

    task automatic test_div1_wrap();
        logic [7:0] prev;
        logic       wrapped;
        run = 1'b1; div = 4'd0; load_div = 1'b1;
        tick();
        load_div = 1'b0;
        checks++;
        if (strobe !== 1'b1 || cnt !== exp_cnt) begin errors++; $display("FAIL div0_first: got strobe=%b cnt=%0d expected 1 %0d", strobe, cnt, exp_cnt); end
        wrapped = 1'b0;
        for (int k = 0; k < 260; k++) begin
            prev = cnt;
            tick();
            checks++;
            if (cnt !== exp_cnt || strobe !== 1'b1 || grant !== 4'd0) begin
                errors++;
                $display("FAIL div0_run: got cnt=%0d strobe=%b grant=%b expected %0d 1 0000", cnt, strobe, grant, exp_cnt);
            end
            if (prev == 8'hFF && cnt == 8'h00) wrapped = 1'b1;
        end
        checks++;
        if (wrapped !== 1'b1) begin errors++; $display("FAIL cnt_wrap: got no 255->0 transition, expected one"); end
    endtask

    task automatic test_div3();
        logic hit;
        logic [7:0] pre;
        div = 4'd3; load_div = 1'b1; req = 4'd0; sample_ready = 1'b1;
        tick();
        load_div = 1'b0; req = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            hit = (k % 3 == 0);
            pre = exp_cnt;
            if (hit) begin
                q.push_back(mk(4'b0001, 2'd0, exp_cnt));
                exp_ptr = 2'd1;
            end
            tick();
            checks++;
            if (strobe !== hit || sample_valid !== hit || overrun !== 1'b0) begin
                errors++;
                $display("FAIL div3_cycle: k=%0d got strobe=%b valid=%b overrun=%b expected %b %b 0", k, strobe, sample_valid, overrun, hit, hit);
            end
            if (hit) begin
                checks++;
                if (sample !== pre) begin errors++; $display("FAIL div3_pre_increment: got sample=%0d expected %0d (post-increment is %0d)", sample, pre, exp_cnt); end
            end
        end
    endtask

    task automatic test_round_robin();
        div = 4'd1; load_div = 1'b1; req = 4'd0; sample_ready = 1'b1;
        tick();
        load_div = 1'b0; req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            q.push_back(mk(4'b0001 << exp_ptr, exp_ptr, exp_cnt));
            exp_ptr = exp_ptr + 2'd1;
            tick();
            checks++;
            if (sample_valid !== 1'b1 || strobe !== 1'b1) begin errors++; $display("FAIL rr_valid: j=%0d got valid=%b strobe=%b expected 1 1", j, sample_valid, strobe); end
        end
        req = 4'd0;
        tick();
        checks++;
        if (grant !== 4'd0 || sample_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got grant=%b valid=%b expected 0000 0", grant, sample_valid); end
    endtask

    task automatic test_overrun();
        logic [7:0] held;
        div = 4'd2; load_div = 1'b1; req = 4'd0; sample_ready = 1'b0;
        tick();
        load_div = 1'b0; req = 4'b0011;
        tick();
        checks++;
        if (strobe !== 1'b0 || sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_idle: got strobe=%b valid=%b expected 0 0", strobe, sample_valid); end
        held = exp_cnt;
        q.push_back(mk(4'b0001, 2'd0, exp_cnt));
        exp_ptr = 2'd1;
        tick();
        checks++;
        if (sample_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got valid=%b overrun=%b expected 1 0", sample_valid, overrun); end
        tick();
        checks++;
        if (sample !== held || sample_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_hold: got sample=%0d valid=%b overrun=%b expected %0d 1 0", sample, sample_valid, overrun, held); end
        tick();
        checks++;
        if (overrun !== 1'b1 || grant !== 4'd0 || sample !== held || sample_id !== 2'd0 || sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_pulse: got overrun=%b grant=%b sample=%0d id=%0d valid=%b expected 1 0000 %0d 0 1", overrun, grant, sample, sample_id, sample_valid, held);
        end
        tick();
        checks++;
        if (overrun !== 1'b0 || sample !== held) begin errors++; $display("FAIL ovr_one_cycle: got overrun=%b sample=%0d expected 0 %0d", overrun, sample, held); end
        sample_ready = 1'b1;
        q.push_back(mk(4'b0010, 2'd1, exp_cnt));
        exp_ptr = 2'd2;
        tick();
        sample_ready = 1'b0; req = 4'd0;
        checks++;
        if (sample_valid !== 1'b1 || sample_id !== 2'd1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_accept_regrant: got valid=%b id=%0d overrun=%b expected 1 1 0", sample_valid, sample_id, overrun); end
    endtask

    task automatic test_run_stop();
        logic [7:0] frozen;
        run = 1'b0;
        frozen = exp_cnt;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (cnt !== frozen || strobe !== 1'b0 || sample_valid !== 1'b1 || sample_id !== 2'd1) begin
                errors++;
                $display("FAIL stop_hold: got cnt=%0d strobe=%b valid=%b id=%0d expected %0d 0 1 1", cnt, strobe, sample_valid, sample_id, frozen);
            end
        end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL stop_accept: got valid=%b expected 0", sample_valid); end
    endtask

    task automatic test_async_reset();
        div = 4'd1; load_div = 1'b1; run = 1'b1; req = 4'd0; sample_ready = 1'b0;
        tick();
        load_div = 1'b0;
        for (int k = 0; k < 300 && exp_cnt != 8'h7E; k++) tick();
        req = 4'b0001;
        q.push_back(mk(4'b0001, 2'd0, 8'h7E));
        exp_ptr = 2'd1;
        tick();
        req = 4'd0; run = 1'b0;
        checks++;
        if (cnt !== 8'h7F || sample_valid !== 1'b1) begin errors++; $display("FAIL arst_setup: got cnt=%h valid=%b expected 7f 1", cnt, sample_valid); end
        #2;
        reset_l = 1'b0;
        #1;
        checks++;
        if (cnt !== 8'd0 || sample !== 8'd0 || grant !== 4'd0 || sample_id !== 2'd0 || {strobe, sample_valid, overrun} !== 3'b000) begin
            errors++;
            $display("FAIL arst_immediate: got cnt=%0d sample=%0d grant=%b id=%0d s/v/o=%b expected all zero", cnt, sample, grant, sample_id, {strobe, sample_valid, overrun});
        end
        exp_cnt = 8'd0;
        exp_ptr = 2'd0;
        @(negedge clk);
        reset_l = 1'b1;
        run = 1'b1; req = 4'b0110; sample_ready = 1'b1;
        q.push_back(mk(4'b0010, 2'd1, exp_cnt));
        exp_ptr = 2'd2;
        tick();
        checks++;
        if (strobe !== 1'b1 || cnt !== 8'd1) begin errors++; $display("FAIL arst_ratio1: got strobe=%b cnt=%0d expected 1 1", strobe, cnt); end
        q.push_back(mk(4'b0100, 2'd2, exp_cnt));
        exp_ptr = 2'd3;
        tick();
        req = 4'd0; run = 1'b0;
        tick();
        checks++;
        if (sample_valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL end_drain: got valid=%b pending=%0d expected 0 0", sample_valid, q.size()); end
    endtask

    initial begin
        test_reset();
        test_div1_wrap();
        test_div3();
        test_round_robin();
        test_overrun();
        test_run_stop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
